// File: rtl/rgmii_rx_pkg.sv
// Shared types and Ethernet length limits for the RGMII receive frame controller.
package rgmii_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        DISCARD
    } state_t;

    localparam int unsigned ETH_MIN_LEN = 64;
    localparam int unsigned ETH_MAX_LEN = 1522;

    typedef struct packed {
        logic [7:0] data;
        logic       val;
        logic       sof;
        logic       eof;
        logic       err;
    } beat_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rgmii_rx_frame_ctrl.sv
// Frame gating behind the RGMII receive FIFO: admits, length-checks and force-closes
// frames, emitting one registered beat per input beat and keeping frame statistics.
module rgmii_rx_frame_ctrl
    import rgmii_rx_pkg::*;
#(
    parameter int unsigned MIN_LEN     = ETH_MIN_LEN,
    parameter int unsigned MAX_LEN     = ETH_MAX_LEN,
    parameter int unsigned GAP_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk125,
    input  logic             rst,
    input  logic             Enable,
    input  logic             Cnt_Clr,
    input  logic             LINK_UP,
    input  logic [7:0]       Data_In,
    input  logic             Val_In,
    input  logic             SoF_In,
    input  logic             EoF_In,
    input  logic             Err_In,
    output logic [7:0]       Data_Out,
    output logic             Val_Out,
    output logic             SoF_Out,
    output logic             EoF_Out,
    output logic             Err_Out,
    output logic [CNT_W-1:0] Cnt_Good,
    output logic [CNT_W-1:0] Cnt_Bad,
    output logic [CNT_W-1:0] Cnt_Drop
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);
    localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MIN_L    = LEN_W'(MIN_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
    localparam beat_t FORCED_CLOSE = '{data: 8'h00, val: 1'b1, sof: 1'b0, eof: 1'b1, err: 1'b1};

    state_t           state, state_next;
    beat_t            beat_q, beat_d;
    logic [LEN_W-1:0] len, len_next, len_inc;
    logic [GAP_W-1:0] gap, gap_next;
    logic             err, err_next;
    logic             gap_expire, short_bad;
    logic             inc_good, inc_bad, inc_drop;

    assign len_inc    = len + LEN_W'(1);
    // Expiry fires on the GAP_TIMEOUT-th consecutive idle cycle, so it never competes with a beat.
    assign gap_expire = (state != IDLE) && !Val_In && (gap == GAP_LAST);
    assign short_bad  = err || Err_In || (len_inc < MIN_L);

    always_ff @(posedge clk125) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (Val_In && SoF_In) begin
                    if (LINK_UP && Enable) begin
                        state_next = EoF_In ? IDLE : FRAME;
                    end else begin
                        state_next = EoF_In ? IDLE : DISCARD;
                    end
                end
            end
            FRAME: begin
                if (!LINK_UP || gap_expire) begin
                    state_next = IDLE;
                end else if (Val_In) begin
                    if (SoF_In) begin
                        state_next = EoF_In ? IDLE : DISCARD;
                    end else if (EoF_In) begin
                        state_next = IDLE;
                    end else if (len_inc == MAX_L) begin
                        state_next = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (!LINK_UP || gap_expire || (Val_In && EoF_In)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        beat_d   = '0;
        len_next = len;
        err_next = err;
        inc_good = 1'b0;
        inc_bad  = 1'b0;
        inc_drop = 1'b0;
        unique case (state)
            IDLE: begin
                if (Val_In && SoF_In) begin
                    if (LINK_UP && Enable) begin
                        len_next = LEN_W'(1);
                        err_next = Err_In;
                        beat_d   = '{data: Data_In, val: 1'b1, sof: 1'b1, eof: EoF_In,
                                     err: EoF_In && (Err_In || (MIN_LEN > 1))};
                        inc_good = EoF_In && !beat_d.err;
                        inc_bad  = EoF_In && beat_d.err;
                    end else begin
                        inc_drop = 1'b1;
                    end
                end
            end
            FRAME: begin
                if (!LINK_UP || gap_expire) begin
                    beat_d  = FORCED_CLOSE;
                    inc_bad = 1'b1;
                end else if (Val_In) begin
                    len_next = (len == MAX_L) ? len : len_inc;
                    err_next = err || Err_In;
                    beat_d   = '{data: Data_In, val: 1'b1, sof: 1'b0, eof: 1'b0, err: 1'b0};
                    if (SoF_In) begin
                        beat_d.eof = 1'b1;
                        beat_d.err = 1'b1;
                        inc_bad    = 1'b1;
                        inc_drop   = 1'b1;
                    end else if (EoF_In) begin
                        beat_d.eof = 1'b1;
                        beat_d.err = short_bad;
                        inc_good   = !short_bad;
                        inc_bad    = short_bad;
                    end else if (len_inc == MAX_L) begin
                        beat_d.eof = 1'b1;
                        beat_d.err = 1'b1;
                        inc_bad    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        gap_next = Val_In ? '0 : gap + GAP_W'(1);
        if (state_next == IDLE) begin
            gap_next = '0;
        end
    end

    always_ff @(posedge clk125) begin
        if (rst) begin
            beat_q <= '0;
            len    <= '0;
            gap    <= '0;
            err    <= 1'b0;
        end else begin
            beat_q <= beat_d;
            len    <= len_next;
            gap    <= gap_next;
            err    <= err_next;
        end
    end

    assign Data_Out = beat_q.data;
    assign Val_Out  = beat_q.val;
    assign SoF_Out  = beat_q.sof;
    assign EoF_Out  = beat_q.eof;
    assign Err_Out  = beat_q.err;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_good (
        .clk(clk125), .rst(rst), .clr(Cnt_Clr), .inc(inc_good), .count(Cnt_Good)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_bad (
        .clk(clk125), .rst(rst), .clr(Cnt_Clr), .inc(inc_bad), .count(Cnt_Bad)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_drop (
        .clk(clk125), .rst(rst), .clr(Cnt_Clr), .inc(inc_drop), .count(Cnt_Drop)
    );

endmodule

// File: tb/tb_rgmii_rx_frame_ctrl.sv
// Bench for rgmii_rx_frame_ctrl: directed scenarios plus random traffic against a frame-level model.
module tb_rgmii_rx_frame_ctrl;

    localparam int CW   = 4;
    localparam int MINL = 64;
    localparam int MAXL = 1522;
    localparam int GAPT = 64;

    logic          clk125 = 1'b0;
    logic          rst = 1'b1, enable = 1'b1, cnt_clr = 1'b0, link_up = 1'b1;
    logic [7:0]    data_in = '0;
    logic          val_in = 1'b0, sof_in = 1'b0, eof_in = 1'b0, err_in = 1'b0;
    logic [7:0]    data_out;
    logic          val_out, sof_out, eof_out, err_out;
    logic [CW-1:0] cnt_good, cnt_bad, cnt_drop;
    logic [11:0]   obs;

    int n_vec = 0;
    int n_err = 0;

    // Model: frame bookkeeping as plain counters and flags
    logic [11:0] mexp;
    bit m_open, m_skip, m_err;
    int m_beats, m_idle, m_good, m_bad, m_drop;

    rgmii_rx_frame_ctrl #(
        .MIN_LEN(MINL), .MAX_LEN(MAXL), .GAP_TIMEOUT(GAPT), .CNT_W(CW)
    ) dut (
        .clk125(clk125), .rst(rst), .Enable(enable), .Cnt_Clr(cnt_clr), .LINK_UP(link_up),
        .Data_In(data_in), .Val_In(val_in), .SoF_In(sof_in), .EoF_In(eof_in), .Err_In(err_in),
        .Data_Out(data_out), .Val_Out(val_out), .SoF_Out(sof_out), .EoF_Out(eof_out),
        .Err_Out(err_out), .Cnt_Good(cnt_good), .Cnt_Bad(cnt_bad), .Cnt_Drop(cnt_drop)
    );

    assign obs = {data_out, val_out, sof_out, eof_out, err_out};

    always #4 clk125 = ~clk125;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    task automatic model_step();
        bit g, b, d, bad_frame;
        g = 0; b = 0; d = 0;
        mexp = '0;
        if (rst) begin
            m_open = 0; m_skip = 0; m_err = 0; m_beats = 0; m_idle = 0;
            m_good = 0; m_bad = 0; m_drop = 0;
            return;
        end
        if (m_open) begin
            if (!link_up || (!val_in && m_idle + 1 >= GAPT)) begin
                mexp = 12'h00B; b = 1; m_open = 0;
            end else if (!val_in) begin
                m_idle++;
            end else begin
                m_idle = 0;
                m_beats++;
                m_err = m_err | err_in;
                if (sof_in) begin
                    mexp = {data_in, 4'b1011}; b = 1; d = 1; m_open = 0; m_skip = !eof_in;
                end else if (eof_in) begin
                    bad_frame = m_err || (m_beats < MINL);
                    mexp = {data_in, 3'b101, bad_frame};
                    g = !bad_frame; b = bad_frame; m_open = 0;
                end else if (m_beats == MAXL) begin
                    mexp = {data_in, 4'b1011}; b = 1; m_open = 0; m_skip = 1;
                end else begin
                    mexp = {data_in, 4'b1000};
                end
            end
        end else if (m_skip) begin
            if (!link_up || (val_in && eof_in) || (!val_in && m_idle + 1 >= GAPT)) begin
                m_skip = 0; m_idle = 0;
            end else begin
                m_idle = val_in ? 0 : m_idle + 1;
            end
        end else if (val_in && sof_in) begin
            m_idle = 0;
            if (link_up && enable) begin
                m_beats = 1;
                m_err = err_in;
                bad_frame = err_in || (MINL > 1);
                mexp = {data_in, 2'b11, eof_in, eof_in && bad_frame};
                if (eof_in) begin g = !bad_frame; b = bad_frame; end
                else m_open = 1;
            end else begin
                d = 1; m_skip = !eof_in;
            end
        end
        if (cnt_clr) begin
            m_good = 0; m_bad = 0; m_drop = 0;
        end else begin
            if (g && m_good < (1 << CW) - 1) m_good++;
            if (b && m_bad  < (1 << CW) - 1) m_bad++;
            if (d && m_drop < (1 << CW) - 1) m_drop++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk125);
        #1;
    endtask

    task automatic drive(input bit v, input bit s, input bit e, input bit er, input logic [7:0] d);
        val_in = v; sof_in = s; eof_in = e; err_in = er; data_in = d;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 8'h00);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 0, 0, 8'hA5);
        drive(1, 0, 0, 0, 8'h5A);
        n_vec++;
        if (obs !== 12'h000 || {cnt_good, cnt_bad, cnt_drop} !== '0) begin
            n_err++;
            $display("FAIL reset: beat %h cnt %h/%h/%h, required 000 and 0/0/0",
                     obs, cnt_good, cnt_bad, cnt_drop);
        end
        rst = 1'b0;
    endtask

    task automatic test_good_frame();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            drive(1, i == 0, i == 63, 0, 8'(i));
            n_vec++;
            if (obs !== mexp || (i == 0 && obs !== 12'h00C) || (i == 63 && obs !== {8'd63, 4'b1010})) begin
                n_err++;
                $display("FAIL good_frame beat %0d: got %h, model %h", i, obs, mexp);
            end
        end
        drive(0, 0, 0, 0, 8'h00);
        n_vec++;
        if (obs !== 12'h000 || cnt_good !== CW'(1) || cnt_bad !== '0) begin
            n_err++;
            $display("FAIL good_frame end: beat %h good %0d bad %0d, required 000 1 0", obs, cnt_good, cnt_bad);
        end
    endtask

    task automatic test_short();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(1, i == 0, i == 39, 0, 8'($urandom));
            n_vec++;
            if (obs !== mexp || (i == 39 && obs[3:0] !== 4'b1011)) begin
                n_err++;
                $display("FAIL short_frame beat %0d: got %h, model %h", i, obs, mexp);
            end
        end
        drive(1, 1, 1, 0, 8'h3C);
        n_vec++;
        if (obs !== {8'h3C, 4'b1111}) begin
            n_err++;
            $display("FAIL one_byte: got %h, required %h", obs, {8'h3C, 4'b1111});
        end
        drive(0, 0, 0, 0, 8'h00);
        n_vec++;
        if (cnt_bad !== CW'(2) || cnt_good !== '0) begin
            n_err++;
            $display("FAIL short_counts: bad %0d good %0d, required 2 0", cnt_bad, cnt_good);
        end
    endtask

    task automatic test_max_len();
        do_reset();
        for (int i = 0; i < 1600; i++) begin
            drive(1, i == 0, 0, 0, 8'($urandom));
            n_vec++;
            if (obs !== mexp || (i == MAXL - 1 && obs[3:0] !== 4'b1011) || (i >= MAXL && obs[3] !== 1'b0)) begin
                n_err++;
                $display("FAIL max_len beat %0d: got %h, model %h", i + 1, obs, mexp);
            end
        end
        for (int i = 0; i < 70; i++) drive(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 64; i++) begin
            drive(1, i == 0, i == 63, 0, 8'(i + 7));
            n_vec++;
            if (obs !== mexp) begin
                n_err++;
                $display("FAIL max_len next beat %0d: got %h, model %h", i, obs, mexp);
            end
        end
        drive(0, 0, 0, 0, 8'h00);
        n_vec++;
        if (cnt_bad !== CW'(1) || cnt_good !== CW'(1)) begin
            n_err++;
            $display("FAIL max_len counts: bad %0d good %0d, required 1 1", cnt_bad, cnt_good);
        end
    endtask

    task automatic test_link_gap();
        do_reset();
        for (int i = 0; i < 100; i++) drive(1, i == 0, 0, 0, 8'(i));
        link_up = 1'b0;
        drive(0, 0, 0, 0, 8'h00);
        n_vec++;
        if (obs !== 12'h00B || obs !== mexp) begin
            n_err++;
            $display("FAIL link_drop: got %h, required 00B", obs);
        end
        link_up = 1'b1;
        for (int i = 0; i < 100; i++) drive(1, i == 0, 0, 0, 8'(i));
        for (int k = 0; k < GAPT; k++) begin
            drive(0, 0, 0, 0, 8'h00);
            n_vec++;
            if (obs !== mexp || obs !== ((k == GAPT - 1) ? 12'h00B : 12'h000)) begin
                n_err++;
                $display("FAIL gap idle %0d: got %h, model %h", k + 1, obs, mexp);
            end
        end
        drive(0, 0, 0, 0, 8'h00);
        n_vec++;
        if (cnt_bad !== CW'(2) || obs !== 12'h000) begin
            n_err++;
            $display("FAIL link_gap counts: bad %0d beat %h, required 2 000", cnt_bad, obs);
        end
    endtask

    task automatic test_enable();
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 64; i++) begin
            drive(1, i == 0, i == 63, 0, 8'(i));
            n_vec++;
            if (obs !== 12'h000 || obs !== mexp) begin
                n_err++;
                $display("FAIL disabled beat %0d: got %h, required 000", i, obs);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i == 10) enable = 1'b0;
            drive(1, i == 0, i == 63, 0, 8'(i));
            n_vec++;
            if (obs !== mexp || (i == 63 && obs !== {8'd63, 4'b1010})) begin
                n_err++;
                $display("FAIL enable_mid beat %0d: got %h, model %h", i, obs, mexp);
            end
        end
        enable = 1'b1;
        drive(0, 0, 0, 0, 8'h00);
        n_vec++;
        if (cnt_drop !== CW'(1) || cnt_good !== CW'(1)) begin
            n_err++;
            $display("FAIL enable counts: drop %0d good %0d, required 1 1", cnt_drop, cnt_good);
        end
    endtask

    task automatic test_sof_in_frame();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            drive(1, i == 0 || i == 30, i == 63, 0, 8'(i + 100));
            n_vec++;
            if (obs !== mexp || (i == 30 && obs !== {8'd130, 4'b1011}) || (i > 30 && obs !== 12'h000)) begin
                n_err++;
                $display("FAIL sof_in_frame beat %0d: got %h, model %h", i, obs, mexp);
            end
        end
        drive(0, 0, 0, 0, 8'h00);
        n_vec++;
        if (cnt_bad !== CW'(1) || cnt_drop !== CW'(1) || cnt_good !== '0) begin
            n_err++;
            $display("FAIL sof_in_frame counts: bad %0d drop %0d good %0d, required 1 1 0",
                     cnt_bad, cnt_drop, cnt_good);
        end
    endtask

    task automatic test_clear();
        cnt_clr = 1'b1;
        drive(0, 0, 0, 0, 8'h00);
        cnt_clr = 1'b0;
        n_vec++;
        if ({cnt_good, cnt_bad, cnt_drop} !== '0) begin
            n_err++;
            $display("FAIL cnt_clr: %0d/%0d/%0d, required 0/0/0", cnt_good, cnt_bad, cnt_drop);
        end
        enable = 1'b0;
        cnt_clr = 1'b1;
        drive(1, 1, 1, 0, 8'h11);
        cnt_clr = 1'b0;
        n_vec++;
        if (cnt_drop !== '0) begin
            n_err++;
            $display("FAIL clr_vs_inc: drop %0d, required 0", cnt_drop);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 1, 0, 8'(i));
            drive(0, 0, 0, 0, 8'h00);
        end
        n_vec++;
        if (cnt_drop !== '1 || m_drop != 15) begin
            n_err++;
            $display("FAIL saturate: drop %0d, required 15", cnt_drop);
        end
        enable = 1'b1;
        for (int i = 0; i < 10; i++) drive(1, i == 0, 0, 0, 8'(i));
        rst = 1'b1;
        drive(1, 0, 0, 0, 8'h77);
        rst = 1'b0;
        n_vec++;
        if (obs !== 12'h000 || {cnt_good, cnt_bad, cnt_drop} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_frame: beat %h cnt %0d/%0d/%0d, required 000 0/0/0",
                     obs, cnt_good, cnt_bad, cnt_drop);
        end
        drive(1, 0, 1, 0, 8'h78);
        n_vec++;
        if (obs !== 12'h000 || obs !== mexp) begin
            n_err++;
            $display("FAIL after_rst: got %h, required 000", obs);
        end
    endtask

    task automatic test_random();
        int burst;
        burst = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bit v;
            if (burst == 0 && $urandom_range(0, 299) == 0) burst = $urandom_range(40, 90);
            v = (burst == 0) && ($urandom_range(0, 9) < 8);
            if (burst > 0) burst--;
            link_up = ($urandom_range(0, 599) != 0);
            enable  = ($urandom_range(0, 14) != 0);
            cnt_clr = ($urandom_range(0, 499) == 0);
            drive(v, v && ($urandom_range(0, 39) == 0), v && ($urandom_range(0, 59) == 0),
                  v && ($urandom_range(0, 99) == 0), 8'($urandom));
            n_vec++;
            if (obs !== mexp || cnt_good !== CW'(m_good) || cnt_bad !== CW'(m_bad) || cnt_drop !== CW'(m_drop)) begin
                n_err++;
                $display("FAIL random cycle %0d: beat %h cnt %0d/%0d/%0d, model %h %0d/%0d/%0d",
                         c, obs, cnt_good, cnt_bad, cnt_drop, mexp, m_good, m_bad, m_drop);
            end
        end
        link_up = 1'b1; enable = 1'b1; cnt_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short();
        test_max_len();
        test_link_gap();
        test_enable();
        test_sof_in_frame();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
